// File: rtl/jacobi_stream_fifo_pkg.sv
// Shared constants and payload types for the Jacobi rotation result path.
package jacobi_stream_fifo_pkg;

  localparam int unsigned JACOBI_OUTPUT_WORD_WIDTH = 32;
  localparam int unsigned JACOBI_FIFO_DEPTH        = 32;
  localparam int unsigned JACOBI_CORDIC_LATENCY    = 16;
  localparam int unsigned JACOBI_ROT_CH            = 3;

  typedef struct packed {
    logic [JACOBI_OUTPUT_WORD_WIDTH-1:0] z;
    logic [JACOBI_OUTPUT_WORD_WIDTH-1:0] y;
    logic [JACOBI_OUTPUT_WORD_WIDTH-1:0] x;
  } jacobi_rot_word_t;

  // Flatten a rotation word so channel 0 (x) lands in the LSBs of the FIFO data bus.
  function automatic logic [JACOBI_ROT_CH*JACOBI_OUTPUT_WORD_WIDTH-1:0] jacobi_pack_rot(
    input jacobi_rot_word_t w
  );
    return {w.z, w.y, w.x};
  endfunction

endpackage

// File: rtl/jacobi_stream_fifo.sv
// Multi-channel first-word-fall-through FIFO buffering CORDIC rotation results,
// with a latency-sized almost-full throttle, occupancy count and sticky overflow.
module jacobi_stream_fifo
  import jacobi_stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = JACOBI_OUTPUT_WORD_WIDTH,
  parameter int unsigned NUM_CH       = JACOBI_ROT_CH,
  parameter int unsigned DEPTH        = JACOBI_FIFO_DEPTH,
  parameter int unsigned PIPE_LATENCY = JACOBI_CORDIC_LATENCY,
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         s_tvalid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata_i,
  input  logic                         s_tlast_i,
  output logic                         m_tvalid_o,
  output logic [NUM_CH*DATA_WIDTH-1:0] m_tdata_o,
  output logic                         m_tlast_o,
  input  logic                         m_tready_i,
  output logic                         almost_full_o,
  output logic                         full_o,
  output logic [CNT_W-1:0]             count_o,
  output logic                         overflow_o
);

  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned ENTRY_W   = NUM_CH * DATA_WIDTH + 1;
  localparam int unsigned AF_THRESH = DEPTH - PIPE_LATENCY;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_valid;
  logic               r_full;
  logic               r_almost_full;
  logic               r_overflow;

  logic               w_rd_en;
  logic               w_wr_en;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [ENTRY_W-1:0] w_head;

  // Enables and next-state occupancy; a full FIFO still accepts a write paired with a read.
  always_comb begin
    w_rd_en     = r_valid && m_tready_i;
    w_wr_en     = s_tvalid_i && (!r_full || w_rd_en);
    w_count_nxt = r_count;
    if (w_wr_en && !w_rd_en) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_wr_en && w_rd_en) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_valid       <= 1'b0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else if (flush_i) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_valid       <= 1'b0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count       <= w_count_nxt;
      r_valid       <= (w_count_nxt != '0);
      r_full        <= (w_count_nxt == CNT_W'(DEPTH));
      r_almost_full <= (w_count_nxt >= CNT_W'(AF_THRESH));
      if (s_tvalid_i && !w_wr_en) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage is left unreset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en && !flush_i) begin
      r_mem[r_wr_ptr] <= {s_tlast_i, s_tdata_i};
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign m_tdata_o     = w_head[ENTRY_W-2:0];
  assign m_tlast_o     = w_head[ENTRY_W-1];
  assign m_tvalid_o    = r_valid;
  assign full_o        = r_full;
  assign almost_full_o = r_almost_full;
  assign count_o       = r_count;
  assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_jacobi_stream_fifo.sv
// Scoreboard bench for jacobi_stream_fifo: stimulus pushes expected words, a monitor pops on accept.
module tb_jacobi_stream_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned NCH   = 3;
  localparam int unsigned DEP   = 32;
  localparam int unsigned PL    = 16;
  localparam int unsigned CW    = $clog2(DEP + 1);
  localparam int unsigned W     = NCH * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_i = 1'b0;
  logic          s_tvalid_i = 1'b0;
  logic [W-1:0]  s_tdata_i = '0;
  logic          s_tlast_i = 1'b0;
  logic          m_tvalid_o;
  logic [W-1:0]  m_tdata_o;
  logic          m_tlast_o;
  logic          m_tready_i = 1'b0;
  logic          almost_full_o;
  logic          full_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;

  jacobi_stream_fifo #(
    .DATA_WIDTH  (DW),
    .NUM_CH      (NCH),
    .DEPTH       (DEP),
    .PIPE_LATENCY(PL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .s_tvalid_i   (s_tvalid_i),
    .s_tdata_i    (s_tdata_i),
    .s_tlast_i    (s_tlast_i),
    .m_tvalid_o   (m_tvalid_o),
    .m_tdata_o    (m_tdata_o),
    .m_tlast_o    (m_tlast_o),
    .m_tready_i   (m_tready_i),
    .almost_full_o(almost_full_o),
    .full_o       (full_o),
    .count_o      (count_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_err = 0;
  logic [W:0]    exp_q[$];
  int            m_cnt = 0;
  logic          m_ovf = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] w(input int unsigned v);
    return {32'(v) + 32'd2, 32'(v) + 32'd1, 32'(v)};
  endfunction

  // Monitor: every accepted head word must match the front of the scoreboard.
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (!rst && !flush_i && m_tvalid_o && m_tready_i) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", {m_tlast_o, m_tdata_o}, '1);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", {m_tlast_o, m_tdata_o}, e);
        end
      end
    end
  end

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic l,
                     input logic rdy, input logic fl);
    logic rd, wr;
    s_tvalid_i = v;
    s_tdata_i  = d;
    s_tlast_i  = l;
    m_tready_i = rdy;
    flush_i    = fl;
    rd = (m_cnt != 0) && rdy;
    wr = v && ((m_cnt < DEP) || rd);
    if (!fl && wr) exp_q.push_back({l, d});
    @(posedge clk);
    #1;
    if (fl) begin
      m_cnt = 0;
      m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      if (wr && !rd) m_cnt++;
      else if (rd && !wr) m_cnt--;
      if (v && !wr) m_ovf = 1'b1;
    end
    s_tvalid_i = 1'b0;
    flush_i    = 1'b0;
    chk("count", 128'(count_o), 128'(m_cnt));
    chk("valid", 128'(m_tvalid_o), 128'(m_cnt != 0));
    chk("full", 128'(full_o), 128'(m_cnt == DEP));
    chk("almost_full", 128'(almost_full_o), 128'(m_cnt >= DEP - PL));
    chk("overflow", 128'(overflow_o), 128'(m_ovf));
  endtask

  initial begin
    int sent;
    int guard;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 128'(count_o), 128'(0));
    chk("rst_valid", 128'(m_tvalid_o), 128'(0));
    chk("rst_full", 128'(full_o), 128'(0));
    chk("rst_af", 128'(almost_full_o), 128'(0));
    chk("rst_ovf", 128'(overflow_o), 128'(0));
    rst = 1'b0;

    // Single word with last flag, then one accept.
    cyc(1'b1, {32'd3, 32'd2, 32'd1}, 1'b1, 1'b0, 1'b0);
    chk("single_data", 128'(m_tdata_o), 128'({32'd3, 32'd2, 32'd1}));
    chk("single_last", 128'(m_tlast_o), 128'(1));
    chk("single_count", 128'(count_o), 128'(1));
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("single_drained", 128'(count_o), 128'(0));

    // Fill to full with no reads; almost_full rises at 16.
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, w(i), 1'b0, 1'b0, 1'b0);
      if (i == 14) chk("af_at_15", 128'(almost_full_o), 128'(0));
      if (i == 15) chk("af_at_16", 128'(almost_full_o), 128'(1));
    end
    chk("full_at_32", 128'(full_o), 128'(1));

    // Full with simultaneous read and write: heads 0..9 leave, count holds, no overflow.
    for (int i = 0; i < 10; i++) cyc(1'b1, w(100 + i), 1'b0, 1'b1, 1'b0);
    chk("full_rw_count", 128'(count_o), 128'(32));
    chk("full_rw_ovf", 128'(overflow_o), 128'(0));

    // Write while full with no read is dropped and flags overflow.
    cyc(1'b1, w(999), 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 128'(overflow_o), 128'(1));
    chk("ovf_count", 128'(count_o), 128'(32));

    // Drain: 10..31 then 100..109.
    for (int i = 0; i < 32; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("drain_empty", 128'(count_o), 128'(0));
    chk("ovf_sticky", 128'(overflow_o), 128'(1));

    // Write into empty with ready high: no same-cycle bypass.
    cyc(1'b1, w(7), 1'b1, 1'b1, 1'b0);
    chk("empty_rw_count", 128'(count_o), 128'(1));
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Flush with 5 words held and overflow set, while write and read are requested.
    for (int i = 0; i < 33; i++) cyc(1'b1, w(40 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 27; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("pre_flush_count", 128'(count_o), 128'(5));
    cyc(1'b1, w(200), 1'b1, 1'b1, 1'b1);
    chk("flush_count", 128'(count_o), 128'(0));
    chk("flush_valid", 128'(m_tvalid_o), 128'(0));
    chk("flush_ovf", 128'(overflow_o), 128'(0));
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("flush_write_dropped", 128'(count_o), 128'(0));

    // 100-word stream with random ready, throttled on the model count.
    sent  = 0;
    guard = 0;
    while ((sent < 100 || m_cnt != 0) && guard < 3000) begin
      if (sent < 100 && m_cnt < int'(DEP - PL)) begin
        cyc(1'b1, w(300 + sent), 1'((sent % 7) == 0), 1'($urandom_range(0, 1)), 1'b0);
        sent++;
      end else begin
        cyc(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      guard++;
    end
    chk("stream_done", 128'(guard < 3000), 128'(1));
    chk("stream_sb_empty", 128'(exp_q.size()), 128'(0));

    // Async reset between edges with 7 words held.
    for (int i = 0; i < 7; i++) cyc(1'b1, w(500 + i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", 128'(count_o), 128'(7));
    #3;
    rst = 1'b1;
    #2;
    chk("arst_count", 128'(count_o), 128'(0));
    chk("arst_valid", 128'(m_tvalid_o), 128'(0));
    chk("arst_af", 128'(almost_full_o), 128'(0));
    m_cnt = 0;
    m_ovf = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, w(32'hABC), 1'b1, 1'b0, 1'b0);
    chk("post_rst_data", 128'(m_tdata_o), 128'(w(32'hABC)));
    chk("post_rst_last", 128'(m_tlast_o), 128'(1));
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("final_sb_empty", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jacobi_stream_fifo.md
Name: jacobi_stream_fifo

Overview:
- Parametrised multi-channel synchronous FIFO that buffers rotation-CORDIC results before the main controller consumes them.
- Replaces the fixed two-word packed FIFO. Adds:
  - configurable lane count, width and depth;
  - an optional last-flag lane;
  - an almost-full throttle sized to the producer pipeline latency;
  - occupancy count, sticky overflow flag, synchronous flush.
- The producer (a CORDIC pipeline) cannot stall, so the throttle tells the controller to stop issuing new rotations early enough.

Parameters:
- DATA_WIDTH, 32, width of one channel word.
- NUM_CH, 3, number of parallel channels (x, y, z).
- DEPTH, 32, entries; must be a power of two and >= 4.
- PIPE_LATENCY, 16, producer in-flight capacity; must be < DEPTH.
- CNT_W, $clog2(DEPTH+1), occupancy width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush_i  in  1  synchronous clear of contents and sticky flag.
- s_tvalid_i  in  1  write strobe; there is no ready, the producer cannot stall.
- s_tdata_i  in  NUM_CH*DATA_WIDTH  channel 0 in the LSBs.
- s_tlast_i  in  1  last-of-sweep marker, stored alongside the data.
- m_tvalid_o  out  1  head entry valid.
- m_tdata_o  out  NUM_CH*DATA_WIDTH  head entry data.
- m_tlast_o  out  1  head entry last flag.
- m_tready_i  in  1  consumer accept.
- almost_full_o  out  1  count >= DEPTH-PIPE_LATENCY.
- full_o  out  1  count == DEPTH.
- count_o  out  CNT_W  current occupancy.
- overflow_o  out  1  sticky, a write was dropped.

Behaviour:
- Reset (async, rst=1):
  - Pointers and count = 0.
  - m_tvalid_o=0, full_o=0, almost_full_o=0 (since PIPE_LATENCY<DEPTH), overflow_o=0.
  - m_tdata_o and m_tlast_o are don't-care while m_tvalid_o=0.
  - Storage array is not reset.
- Storage:
  - Register array of DEPTH entries, each NUM_CH*DATA_WIDTH+1 bits (data plus last).
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- First-word-fall-through output:
  - m_tdata_o and m_tlast_o read combinationally from mem[rd_ptr].
  - m_tvalid_o = (count != 0).
- Write/read enables:
  - wr_en = s_tvalid_i && (!full || rd_en).
  - rd_en = m_tvalid_o && m_tready_i.
- Latency: an entry written at edge N is visible on m_tdata_o with m_tvalid_o=1 after edge N. There is no same-cycle bypass when empty.
- Count:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both occur in the same cycle.
- Full with simultaneous read and write: both succeed, count stays DEPTH, no overflow.
- Full with write only: the write is dropped, overflow_o is set on the next edge, and the contents are untouched.
- Empty with m_tready_i=1: no effect; rd_ptr does not move.
- Flags: almost_full_o, full_o and count_o are registered, derived from the next-state count, and change in the same cycle as the count.
- Flush (flush_i=1, synchronous):
  - Pointers and count go to 0; overflow_o clears.
  - Any write or read in that cycle is ignored.
  - Flush has priority over all other activity.
- Reset asserted mid-burst: everything clears immediately. Entries not yet read are lost, and that is acceptable.
- overflow_o stays set until rst or flush_i.
- Throttle contract: the controller issues no new producer input while almost_full_o=1. With at most PIPE_LATENCY words in flight, full is never exceeded.
- State is implicit (count 0 / partial / almost full / full); there is no explicit FSM beyond the pointer/count logic.

Decomposition:
- Shared package common gains:
  - JACOBI_FIFO_DEPTH (default 32);
  - JACOBI_CORDIC_LATENCY, used for PIPE_LATENCY;
  - typedef jacobi_rot_word_t as a packed struct {x, y, z} of JACOBI_OUTPUT_WORD_WIDTH each.
- No sub-module is needed. The storage array is inline so synthesis infers distributed RAM.
- At top level, NUM_CH=3 with all three CORDIC outputs connected, which fixes the dropped z channel.

Test Plan:
- Single word:
  - Stimulus: after reset, write 0x1/0x2/0x3 with last=1 at edge 0.
  - Required: m_tvalid_o=1 after edge 0, m_tdata_o={3,2,1}, m_tlast_o=1, count_o=1; count_o=0 after one accept.
- Fill to full:
  - Stimulus: DEPTH=32, PIPE_LATENCY=16, 32 consecutive writes of values 0..31 with m_tready_i=0.
  - Required: almost_full_o rises when count_o reaches 16; full_o=1 at 32; a 33rd write sets overflow_o; draining then yields exactly 0..31 in order.
- Simultaneous read and write:
  - When full: continuous write of 100.. with m_tready_i=1 for 10 cycles; count_o stays 32, overflow_o stays 0, and outputs are the old values 0..9.
  - When empty: one write with m_tready_i=1; the word is not popped in the same cycle, and count_o=1 afterwards.
- Pointer wrap:
  - Stimulus: stream 100 words with a random 50% m_tready_i.
  - Required: a scoreboard sees all 100 in order, with no loss or duplication across multiple pointer wraps.
- Flush:
  - Stimulus: fill 5 words, set overflow, then pulse flush_i while s_tvalid_i=1 and m_tready_i=1.
  - Required: the next cycle shows count_o=0, m_tvalid_o=0, overflow_o=0, and the concurrent write is discarded.
- Async reset mid-operation:
  - Stimulus: assert rst between clock edges with count_o=7.
  - Required: outputs clear immediately without a clock; after deassert the first new write reads back correctly at rd_ptr 0.
